// File: rtl/xge_arb_pkg.sv
// Shared constants and FSM encoding for the 10GbE transmit arbiter.
package xge_arb_pkg;
  localparam int DATA_W  = 64;
  localparam int MOD_W   = 3;
  localparam int GRANT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;
endpackage

// File: rtl/xge_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module xge_rr_pick
  import xge_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [GRANT_W-1:0] last,
  output logic [NUM_SRC-1:0] onehot,
  output logic [GRANT_W-1:0] idx
);
  always_comb begin
    logic found;
    int   c;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    c      = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      c = (int'(last) + k) % NUM_SRC;
      // Constant inner index keeps the bit-selects narrow for any NUM_SRC.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && i == c && req[i]) begin
          found     = 1'b1;
          onehot[i] = 1'b1;
          idx       = GRANT_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/xge_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding NUM_SRC packet sources into one MAC TX port.
module xge_tx_arbiter
  import xge_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 32
) (
  input  logic                            clk_156m25,
  input  logic                            reset_156m25_n,
  input  logic [NUM_SRC-1:0]              src_req,
  input  logic [NUM_SRC-1:0]              src_val,
  input  logic [NUM_SRC-1:0]              src_sop,
  input  logic [NUM_SRC-1:0]              src_eop,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data,
  input  logic [NUM_SRC-1:0][MOD_W-1:0]   src_mod,
  output logic [NUM_SRC-1:0]              src_rdy,
  output logic [DATA_W-1:0]               pkt_tx_data,
  output logic                            pkt_tx_val,
  output logic                            pkt_tx_sop,
  output logic                            pkt_tx_eop,
  output logic [MOD_W-1:0]                pkt_tx_mod,
  input  logic                            pkt_tx_full,
  output logic [GRANT_W-1:0]              grant_id,
  output logic                            proto_err,
  output logic [CNT_W-1:0]                pkt_cnt
);
  state_t               state;
  logic [GRANT_W-1:0]   last_grant;
  logic [NUM_SRC-1:0]   own_oh;
  logic                 first_word;

  logic [NUM_SRC-1:0]   pick_oh;
  logic [GRANT_W-1:0]   pick_idx;

  logic [DATA_W-1:0]    sel_data;
  logic [MOD_W-1:0]     sel_mod;
  logic                 sel_sop;
  logic                 sel_eop;
  logic                 accept;

  xge_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req    (src_req),
    .last   (last_grant),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // One-hot owner drives both the ready fan-out and the datapath mux.
  assign src_rdy = (state == ST_XFER && !pkt_tx_full) ? own_oh : '0;
  assign accept  = |(src_val & src_rdy);

  always_comb begin
    sel_data = '0;
    sel_mod  = '0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (own_oh[i]) begin
        sel_data = src_data[i];
        sel_mod  = src_mod[i];
        sel_sop  = src_sop[i];
        sel_eop  = src_eop[i];
      end
    end
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_W'(NUM_SRC - 1);
      grant_id   <= '0;
      own_oh     <= '0;
      first_word <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|src_req) begin
            state      <= ST_XFER;
            grant_id   <= pick_idx;
            own_oh     <= pick_oh;
            first_word <= 1'b1;
          end
        end
        ST_XFER: begin
          if (accept) begin
            first_word <= 1'b0;
            if (sel_eop) begin
              state      <= ST_IDLE;
              last_grant <= grant_id;
              pkt_cnt    <= pkt_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register; sop is rebuilt from grant position so a bad source flag never leaks.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      proto_err   <= 1'b0;
    end else if (accept) begin
      pkt_tx_data <= sel_data;
      pkt_tx_val  <= 1'b1;
      pkt_tx_sop  <= first_word;
      pkt_tx_eop  <= sel_eop;
      pkt_tx_mod  <= sel_mod;
      proto_err   <= first_word ? !sel_sop : sel_sop;
    end else begin
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      proto_err   <= 1'b0;
    end
  end
endmodule

// File: doc/xge_tx_arbiter.md
XGE_TX_ARBITER -- requirements
Module: xge_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, number of packet sources (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 32, width of the forwarded-packet counter.
REQ-003 The block SHALL have port clk_156m25  in  1  the single clock.
REQ-004 The block SHALL have port reset_156m25_n  in  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port src_req  in  NUM_SRC  source i has a packet pending.
REQ-006 The block SHALL have port src_val  in  NUM_SRC  source i data word valid.
REQ-007 The block SHALL have port src_sop / src_eop  in  NUM_SRC each  start/end-of-packet flags per source.
REQ-008 The block SHALL have port src_data  in  NUM_SRC x 64  data word per source.
REQ-009 The block SHALL have port src_mod  in  NUM_SRC x 3  valid-byte count on eop per source (0 = all 8 bytes).
REQ-010 The block SHALL have port src_rdy  out  NUM_SRC  source i word accepted when src_val[i] & src_rdy[i].
REQ-011 The block SHALL have port pkt_tx_data/val/sop/eop/mod  out  64/1/1/1/3  MAC transmit interface.
REQ-012 The block SHALL have port pkt_tx_full  in  1  MAC transmit FIFO full.
REQ-013 The block SHALL have port grant_id  out  3  index of the current owner, valid in XFER.
REQ-014 The block SHALL have port proto_err  out  1  one-cycle pulse on a framing violation.
REQ-015 The block SHALL have port pkt_cnt  out  CNT_W  count of packets forwarded (eop words).

Function
REQ-016 The FSM SHALL have states IDLE and XFER.
REQ-017 In IDLE with any src_req set, the block SHALL select the first requester at or after (last_grant+1) mod NUM_SRC, load grant_id, and enter XFER on the next edge.
REQ-018 In IDLE with no src_req set, the block SHALL stay in IDLE with src_rdy all zero.
REQ-019 In XFER, src_rdy[grant_id] SHALL equal !pkt_tx_full (combinational), and all other src_rdy bits SHALL be 0.
REQ-020 An accepted word SHALL appear on pkt_tx_* registered, one cycle later, with pkt_tx_val=1.
REQ-021 pkt_tx_val SHALL be 0 in any cycle following a cycle with no accepted word.
REQ-022 Acceptance of a word with src_eop set SHALL update last_grant to grant_id, return the FSM to IDLE, and increment pkt_cnt, wrapping modulo 2^CNT_W.
REQ-023 An eop acceptance SHALL cost exactly one idle cycle before the next grant; ownership is packet-atomic, with no preemption.
REQ-024 The first accepted word of a grant without sop SHALL pulse proto_err and be forwarded with pkt_tx_sop forced to 1.
REQ-025 Any later word with sop SHALL pulse proto_err and be forwarded with pkt_tx_sop forced to 0.
REQ-026 If the owner deasserts src_req mid-packet, the block SHALL remain in XFER until eop; src_req is only sampled in IDLE.
REQ-027 A word with both sop and eop set SHALL be legal as a single-word packet.
REQ-028 pkt_tx_full asserting in the same cycle as src_val SHALL cause no acceptance, and src_val SHALL be held by the source.
REQ-029 pkt_tx_mod SHALL pass through src_mod unchanged; it is meaningful only with pkt_tx_eop.

Reset
REQ-030 While reset_156m25_n=0, the block SHALL hold state=IDLE, last_grant=NUM_SRC-1 (so source 0 wins first), grant_id=0, pkt_tx_* = 0, proto_err=0, pkt_cnt=0, and src_rdy=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet immediately, with no eop issued; recovery is the MAC's concern.
REQ-032 Deassertion SHALL take effect at the first clk_156m25 rising edge after release.

Structure
REQ-033 Package xge_arb_pkg SHALL hold the state enum (ST_IDLE, ST_XFER), DATA_W=64, MOD_W=3, and the GRANT_W=3 constant.
REQ-034 The round-robin picker SHALL be a sub-module, xge_rr_pick: a combinational req vector plus last index in, one-hot and index out.
REQ-035 The datapath mux, output register, FSM and counter SHALL stay in xge_tx_arbiter.

Verification
REQ-036 The bench SHALL drive src 0 with a 3-word packet, full=0; pkt_tx sop,-,eop SHALL appear 1 cycle delayed, with pkt_cnt=1 and grant_id=0.
REQ-037 The bench SHALL drive src_req=4'b1111 continuously with 1-word packets; grants SHALL go 0,1,2,3,0, each separated by one idle cycle.
REQ-038 The bench SHALL hold pkt_tx_full=1 for 5 cycles mid-packet; src_rdy SHALL be 0 and pkt_tx_val SHALL be 0 for those cycles, and the data resumes intact.
REQ-039 The bench SHALL send a first word with sop=0 from src 2; proto_err SHALL pulse once and pkt_tx_sop=1 on that word.
REQ-040 The bench SHALL assert reset mid-packet on src 1, then release; the block SHALL be in IDLE, pkt_cnt=0, and the next grant SHALL go to src 0 when all sources request.
REQ-041 The bench SHALL preload pkt_cnt=2^CNT_W-1 via force, then send one packet; pkt_cnt SHALL wrap to 0.
